wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width.
REQ-002 SHALL have parameter REGFILE_COUNT, default 32, meaning number of architectural registers; AW = $clog2(REGFILE_COUNT) (5 at default).
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port alu_valid_i  input  1  ALU writeback request valid.
REQ-006 SHALL have port alu_ready_o  output  1  ALU request accepted this cycle.
REQ-007 SHALL have port alu_rd_i  input  AW  ALU destination register index.
REQ-008 SHALL have port alu_data_i  input  XLEN  ALU writeback data.
REQ-009 SHALL have port lsu_valid_i  input  1  LSU (load) writeback request valid.
REQ-010 SHALL have port lsu_ready_o  output  1  LSU request accepted this cycle.
REQ-011 SHALL have port lsu_rd_i  input  AW  LSU destination register index.
REQ-012 SHALL have port lsu_data_i  input  XLEN  LSU writeback data.
REQ-013 SHALL have port issue_valid_i  input  1  an instruction with a destination register issues this cycle.
REQ-014 SHALL have port issue_rd_i  input  AW  destination index of the issuing instruction.
REQ-015 SHALL have port rf_we_o  output  1  register file write enable.
REQ-016 SHALL have port rf_waddr_o  output  AW  register file write index.
REQ-017 SHALL have port rf_wdata_o  output  XLEN  register file write data.
REQ-018 SHALL have port busy_o  output  REGFILE_COUNT  scoreboard; bit n = register n has an outstanding write.

Function
REQ-019 SHALL accept at most one request per cycle; a transfer occurs when valid and ready are both high on a rising edge.
REQ-020 SHALL drive ready combinationally: a requester's ready is high only if it is the granted requester; a requester with valid low SHALL never see ready high.
REQ-021 SHALL grant a single valid requester immediately, with no cycle lost.
REQ-022 SHALL resolve simultaneous ALU and LSU requests round-robin: the requester not granted most recently wins. The last-grant register updates only on a transfer.
REQ-023 SHALL register the accepted request into rf_we_o/rf_waddr_o/rf_wdata_o on the accepting edge. Latency is 1 cycle from acceptance to write enable. The outputs hold stable for the whole following cycle, so the negative-edge register file write samples settled values.
REQ-024 SHALL deassert rf_we_o in any cycle following no transfer. rf_waddr_o and rf_wdata_o SHALL hold their last values when idle.
REQ-025 SHALL accept requests with rd = 0 (handshake completes normally) but SHALL force rf_we_o low for them (x0 hard-wired zero).
REQ-026 SHALL never back-pressure: the output stage drains every cycle, so whenever any valid is high exactly one ready is high.
REQ-027 SHALL set busy_o[issue_rd_i] on a rising edge with issue_valid_i high, except when issue_rd_i = 0; busy_o[0] SHALL always read 0.
REQ-028 SHALL clear busy_o[n] on the edge where a write to n is accepted (REQ-019), not when rf_we_o later asserts.
REQ-029 SHALL give priority to set when issue and an accepted write target the same register on the same edge; the bit remains 1 (a newer producer is outstanding).
REQ-030 SHALL treat an accepted write to a register whose busy bit is 0 as legal: the write proceeds and the bit stays 0.
REQ-031 SHALL ignore issue_rd_i and requester rd/data inputs whenever the corresponding valid is low.

Reset
REQ-032 SHALL force rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0 and busy_o=0 immediately on rst_ni low, independent of clk_i.
REQ-033 SHALL reset the last-grant register to LSU, so the ALU wins the first tie after reset.
REQ-034 SHALL discard an in-flight accepted write when reset asserts mid-operation (no rf_we_o pulse after reset release without a new transfer); ready outputs SHALL be low while rst_ni is low.

Verification
REQ-035 SHALL cover single ALU request (rd=5, data=0xDEADBEEF): alu_ready_o=1 same cycle; next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF; cycle after, rf_we_o=0.
REQ-036 SHALL cover both requesters valid for 4 cycles after reset (ALU rd=1, LSU rd=2): grants alternate ALU, LSU, ALU, LSU; rf_waddr_o sequence 1,2,1,2 with rf_we_o=1 each cycle.
REQ-037 SHALL cover LSU write to rd=0, data=0x1234: lsu_ready_o=1, rf_we_o stays 0, busy_o unchanged.
REQ-038 SHALL cover issue rd=7, then an ALU write to rd=7 three cycles later: busy_o[7]=1 from the edge after issue until the accepting edge, then 0.
REQ-039 SHALL cover issue rd=9 on the same edge as an accepted LSU write to rd=9 (busy_o[9]=1 beforehand): busy_o[9] remains 1 and the write still commits.
REQ-040 SHALL cover rst_ni pulsed low between acceptance and the write cycle: rf_we_o=0 and busy_o=0 asynchronously, and no write follows release.

Source files
------------

// File: rtl/wb_arbiter.sv
// Register file writeback arbiter: round-robin ALU/LSU grant into one write port, plus a busy scoreboard.
// Latency: 1 cycle from accepting edge to rf_we_o; busy bits update on the accepting or issuing edge.
// Backpressure: never stalls; whenever any valid is high exactly one ready is high (ready is combinational).
module wb_arbiter #(
  parameter int XLEN          = 32,
  parameter int REGFILE_COUNT = 32,
  localparam int AW           = $clog2(REGFILE_COUNT)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  input  logic [AW-1:0]            alu_rd_i,
  input  logic [XLEN-1:0]          alu_data_i,
  input  logic                     lsu_valid_i,
  output logic                     lsu_ready_o,
  input  logic [AW-1:0]            lsu_rd_i,
  input  logic [XLEN-1:0]          lsu_data_i,
  input  logic                     issue_valid_i,
  input  logic [AW-1:0]            issue_rd_i,
  output logic                     rf_we_o,
  output logic [AW-1:0]            rf_waddr_o,
  output logic [XLEN-1:0]          rf_wdata_o,
  output logic [REGFILE_COUNT-1:0] busy_o
);

  // 1 = LSU was granted most recently, so the ALU wins the next tie.
  logic                     r_last_lsu;
  logic                     r_rf_we;
  logic [AW-1:0]            r_rf_waddr;
  logic [XLEN-1:0]          r_rf_wdata;
  logic [REGFILE_COUNT-1:0] r_busy;

  logic                     w_gnt_alu;
  logic                     w_gnt_lsu;
  logic                     w_xfer;
  logic [AW-1:0]            w_rd;
  logic [XLEN-1:0]          w_data;
  logic [REGFILE_COUNT-1:0] w_busy_nxt;

  // Grant selection: a lone requester wins outright, a tie goes to whoever was not granted last.
  // Ready is gated by reset so nothing handshakes while the block is held in reset.
  always_comb begin
    w_gnt_alu = rst_ni && alu_valid_i && (!lsu_valid_i || r_last_lsu);
    w_gnt_lsu = rst_ni && lsu_valid_i && !(alu_valid_i && r_last_lsu);
    w_xfer    = w_gnt_alu || w_gnt_lsu;
    w_rd      = w_gnt_lsu ? lsu_rd_i   : alu_rd_i;
    w_data    = w_gnt_lsu ? lsu_data_i : alu_data_i;
  end

  // Scoreboard next state: accepted write clears, issue sets afterwards so a newer producer wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_xfer) begin
      w_busy_nxt[w_rd] = 1'b0;
    end
    if (issue_valid_i) begin
      w_busy_nxt[issue_rd_i] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Round-robin history only moves when a transfer actually happens.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_lsu <= 1'b1;
    end else if (w_xfer) begin
      r_last_lsu <= w_gnt_lsu;
    end
  end

  // Output stage: capture the accepted request; x0 writes handshake but never enable the write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_we <= w_xfer && (w_rd != '0);
      if (w_xfer) begin
        r_rf_waddr <= w_rd;
        r_rf_wdata <= w_data;
      end
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign alu_ready_o = w_gnt_alu;
  assign lsu_ready_o = w_gnt_lsu;
  assign rf_we_o     = r_rf_we;
  assign rf_waddr_o  = r_rf_waddr;
  assign rf_wdata_o  = r_rf_wdata;
  assign busy_o      = r_busy;

endmodule
